// File: rtl/mips_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_responder_if
// Description : Datapath-to-memory bus between the multicycle MIPS datapath
//               (master) and the memory responder (slave).
//               master drives : memRead, memWrite, memAddr, writeMemData
//               slave drives  : memData, memReady, memErr, memBusy
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_mem_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  memRead;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] writeMemData;
  logic [DATA_WIDTH-1:0] memData;
  logic                  memReady;
  logic                  memErr;
  logic                  memBusy;

  modport master (
    output memRead, memWrite, memAddr, writeMemData,
    input  memData, memReady, memErr, memBusy
  );

  modport slave (
    input  memRead, memWrite, memAddr, writeMemData,
    output memData, memReady, memErr, memBusy
  );
endinterface
`default_nettype wire

// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_responder
// Description : Word-addressed memory answering the multicycle MIPS datapath.
//               Accepts one read/write at a time, responds after WAIT_CYCLES
//               wait states with a one-cycle memReady strobe, and flags
//               misaligned, out-of-range and read/write-conflict requests
//               through memErr.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               bus   - slave side of mips_mem_responder_if
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mem_responder_if.slave  bus
);

  localparam int          c_IDX_W  = ADDR_WIDTH - 2;
  localparam int          c_MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_DEPTH  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT   = 4'(WAIT_CYCLES);
  localparam logic        c_ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_count;
  logic                  r_isRead;
  logic                  r_isWrite;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_memData;
  logic                  r_memReady;
  logic                  r_memErr;
  logic                  r_memBusy;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_req;
  logic                  w_enterResp;
  logic                  w_useLive;
  logic [ADDR_WIDTH-1:0] w_accAddr;
  logic [DATA_WIDTH-1:0] w_accData;
  logic                  w_accWrite;
  logic                  w_accConflict;
  logic [c_IDX_W-1:0]    w_wordIdx;
  logic [c_MEM_AW-1:0]   w_memIdx;
  logic                  w_misaligned;
  logic                  w_outOfRange;
  logic                  w_err;
  logic                  w_doRead;
  logic                  w_doWrite;

  assign w_req = bus.memRead | bus.memWrite;

  // The access happens on the edge that enters RESP. With zero wait states
  // that edge is the accept edge itself, so the request has not been latched
  // yet and the live bus inputs are used instead of the latched copy.
  assign w_enterResp = ((r_state == IDLE) && w_req && c_ZERO_WAIT) ||
                       ((r_state == WAIT) && (r_count == 4'd1));
  assign w_useLive   = (r_state == IDLE);

  assign w_accAddr     = w_useLive ? bus.memAddr      : r_addr;
  assign w_accData     = w_useLive ? bus.writeMemData : r_wdata;
  assign w_accWrite    = w_useLive ? bus.memWrite     : r_isWrite;
  assign w_accConflict = w_useLive ? (bus.memRead & bus.memWrite)
                                   : (r_isRead & r_isWrite);

  // Index bits above the array address width only feed the range check.
  assign w_wordIdx    = w_accAddr[ADDR_WIDTH-1:2];
  assign w_memIdx     = w_wordIdx[c_MEM_AW-1:0];
  assign w_misaligned = |w_accAddr[1:0];
  assign w_outOfRange = (32'(w_wordIdx) >= c_DEPTH);
  assign w_err        = w_misaligned | w_outOfRange | w_accConflict;

  // A conflicting request is a write; a misaligned access touches nothing.
  assign w_doRead  = w_enterResp & ~w_accWrite & ~w_misaligned;
  assign w_doWrite = reset & w_enterResp & w_accWrite & ~w_misaligned & ~w_outOfRange;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_isRead   <= 1'b0;
      r_isWrite  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memData  <= '0;
      r_memReady <= 1'b0;
      r_memErr   <= 1'b0;
      r_memBusy  <= 1'b0;
    end else begin
      r_memReady <= 1'b0;
      r_memErr   <= 1'b0;
      if (w_enterResp) begin
        r_memReady <= 1'b1;
        r_memErr   <= w_err;
      end
      if (w_doRead) begin
        r_memData <= w_outOfRange ? '0 : r_mem[w_memIdx];
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_isRead  <= bus.memRead;
            r_isWrite <= bus.memWrite;
            r_addr    <= bus.memAddr;
            r_wdata   <= bus.writeMemData;
            r_count   <= c_WAIT;
            r_memBusy <= 1'b1;
            r_state   <= c_ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_memBusy <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_memBusy <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Storage is kept out of the reset domain so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[w_memIdx] <= w_accData;
    end
  end

  assign bus.memData  = r_memData;
  assign bus.memReady = r_memReady;
  assign bus.memErr   = r_memErr;
  assign bus.memBusy  = r_memBusy;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_responder
// Description : Directed self-checking bench for mips_mem_responder. dutA runs
//               with two wait states, dutB with zero wait states; both share
//               clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) busA ();
  mips_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) busB ();

  mips_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)
  ) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );

  mips_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)
  ) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit useB, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [31:0] d);
    if (useB) begin
      busB.memRead = rd; busB.memWrite = wr; busB.memAddr = a; busB.writeMemData = d;
    end else begin
      busA.memRead = rd; busA.memWrite = wr; busA.memAddr = a; busA.writeMemData = d;
    end
  endtask

  function automatic logic readyOf(input bit useB);
    return useB ? busB.memReady : busA.memReady;
  endfunction

  // One complete transaction: returns edges from accept to memReady visible
  // (capped at 20), plus the response qualifiers seen with memReady.
  task automatic runTxn(input bit useB, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] rdata);
    @(posedge clk); #1;
    drive(useB, rd, wr, a, d);
    @(posedge clk); #1;
    lat = 0;
    while (!readyOf(useB) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    err   = useB ? busB.memErr  : busA.memErr;
    rdata = useB ? busB.memData : busA.memData;
    drive(useB, 1'b0, 1'b0, a, d);
  endtask

  task automatic test_reset();
    int lat; logic err; logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busA.memReady, busA.memErr, busA.memBusy} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrlA: got %b expected 000", {busA.memReady, busA.memErr, busA.memBusy}); end
    checks++; if (busA.memData !== 32'h0) begin errors++;
      $display("FAIL reset_dataA: got %h expected 00000000", busA.memData); end
    checks++; if ({busB.memReady, busB.memErr, busB.memBusy, busB.memData} !== 35'h0) begin errors++;
      $display("FAIL reset_B: got %h expected 0", {busB.memReady, busB.memErr, busB.memBusy, busB.memData}); end
    @(negedge clk); reset = 1'b1;
    runTxn(1'b0, 1'b0, 1'b1, 16'h0010, 32'h0BADF00D, lat, err, rd);
    runTxn(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h0BADF00D) begin errors++;
      $display("FAIL preload_read: got %h expected 0badf00d", rd); end
    // Start a write and pull reset while it is waiting.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    @(posedge clk); #1;
    checks++; if (busA.memBusy !== 1'b1) begin errors++;
      $display("FAIL accept_busy: got %b expected 1", busA.memBusy); end
    #3 reset = 1'b0;
    #1;
    checks++; if ({busA.memReady, busA.memErr, busA.memBusy, busA.memData} !== 35'h0) begin errors++;
      $display("FAIL async_reset: got %h expected 0", {busA.memReady, busA.memErr, busA.memBusy, busA.memData}); end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busA.memReady, busA.memErr, busA.memBusy, busA.memData} !== 35'h0) begin errors++;
      $display("FAIL held_reset: got %h expected 0", {busA.memReady, busA.memErr, busA.memBusy, busA.memData}); end
    @(negedge clk); reset = 1'b1;
    runTxn(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, lat, err, rd);
    checks++; if (lat !== 2) begin errors++;
      $display("FAIL read_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0BADF00D || err !== 1'b0) begin errors++;
      $display("FAIL aborted_write: got %h err %b expected 0badf00d err 0", rd, err); end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd;
    runTxn(1'b0, 1'b0, 1'b1, 16'h0020, 32'h12345678, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h0BADF00D) begin errors++;
      $display("FAIL write_resp: got err %b data %h expected err 0 data 0badf00d", err, rd); end
    runTxn(1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h12345678) begin errors++;
      $display("FAIL read_back: got err %b data %h expected err 0 data 12345678", err, rd); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] rd;
    runTxn(1'b0, 1'b1, 1'b0, 16'h0022, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h12345678) begin errors++;
      $display("FAIL misaligned_read: got err %b data %h expected err 1 data 12345678", err, rd); end
    runTxn(1'b0, 1'b1, 1'b0, 16'h1000, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL range_read: got err %b data %h expected err 1 data 00000000", err, rd); end
    // 0x1000 aliases word 0 in the low index bits; word 0 must survive.
    runTxn(1'b0, 1'b0, 1'b1, 16'h0000, 32'h00C0FFEE, lat, err, rd);
    runTxn(1'b0, 1'b0, 1'b1, 16'h1000, 32'hFFFFFFFF, lat, err, rd);
    checks++; if (err !== 1'b1) begin errors++;
      $display("FAIL range_write_err: got %b expected 1", err); end
    runTxn(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h00C0FFEE) begin errors++;
      $display("FAIL range_write_drop: got err %b data %h expected err 0 data 00c0ffee", err, rd); end
    // Misaligned and out of range together: misaligned wins, memData kept.
    runTxn(1'b0, 1'b1, 1'b0, 16'h1002, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h00C0FFEE) begin errors++;
      $display("FAIL priority: got err %b data %h expected err 1 data 00c0ffee", err, rd); end
  endtask

  task automatic test_conflict();
    int lat; logic err; logic [31:0] rd;
    runTxn(1'b0, 1'b1, 1'b1, 16'h0008, 32'hA5A5A5A5, lat, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h00C0FFEE) begin errors++;
      $display("FAIL conflict_resp: got err %b data %h expected err 1 data 00c0ffee", err, rd); end
    runTxn(1'b0, 1'b1, 1'b0, 16'h0008, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL conflict_write: got err %b data %h expected err 0 data a5a5a5a5", err, rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [31:0] rd;
    logic [31:0] expData [3];
    int nReady;
    int lastEdge;
    int e;
    expData[0] = 32'h30303030; expData[1] = 32'h34343434; expData[2] = 32'h38383838;
    runTxn(1'b0, 1'b0, 1'b1, 16'h0030, 32'h30303030, lat, err, rd);
    runTxn(1'b0, 1'b0, 1'b1, 16'h0034, 32'h34343434, lat, err, rd);
    runTxn(1'b0, 1'b0, 1'b1, 16'h0038, 32'h38383838, lat, err, rd);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0);
    nReady = 0; lastEdge = 1; e = 0;
    while (nReady < 3 && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (busA.memReady) begin
        checks++; if (e - lastEdge !== (nReady == 0 ? 2 : 4)) begin errors++;
          $display("FAIL b2b_spacing%0d: got %0d expected %0d", nReady, e - lastEdge, (nReady == 0 ? 2 : 4)); end
        checks++; if (busA.memData !== expData[nReady] || busA.memErr !== 1'b0) begin errors++;
          $display("FAIL b2b_data%0d: got %h err %b expected %h err 0", nReady, busA.memData, busA.memErr, expData[nReady]); end
        lastEdge = e;
        nReady++;
        busA.memAddr = 16'h0030 + 16'(4 * nReady);
        if (nReady == 3) busA.memRead = 1'b0;
      end else if (busA.memBusy) begin
        busA.memAddr = 16'h0002;  // scribble during WAIT; latched address must win
      end
    end
    checks++; if (nReady !== 3) begin errors++;
      $display("FAIL b2b_count: got %0d expected 3", nReady); end
    busA.memRead = 1'b0;
  endtask

  task automatic test_zero_wait();
    int lat; logic err; logic [31:0] rd;
    runTxn(1'b1, 1'b0, 1'b1, 16'h0040, 32'h40404040, lat, err, rd);
    checks++; if (lat !== 0 || err !== 1'b0) begin errors++;
      $display("FAIL zw_write: got lat %0d err %b expected lat 0 err 0", lat, err); end
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 32'h0);
    @(posedge clk); #1;
    checks++; if ({busB.memReady, busB.memBusy, busB.memErr} !== 3'b110 || busB.memData !== 32'h40404040) begin errors++;
      $display("FAIL zw_read: got rdy/busy/err %b data %h expected 110 data 40404040",
               {busB.memReady, busB.memBusy, busB.memErr}, busB.memData); end
    drive(1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
    @(posedge clk); #1;
    checks++; if ({busB.memReady, busB.memBusy} !== 2'b00) begin errors++;
      $display("FAIL zw_busy_drop: got %b expected 00", {busB.memReady, busB.memBusy}); end
    runTxn(1'b1, 1'b1, 1'b0, 16'h1000, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL zw_range: got err %b data %h expected err 1 data 00000000", err, rd); end
    runTxn(1'b1, 1'b0, 1'b1, 16'h0041, 32'h99999999, lat, err, rd);
    runTxn(1'b1, 1'b1, 1'b0, 16'h0040, 32'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 32'h40404040) begin errors++;
      $display("FAIL zw_misaligned_write: got err %b data %h expected err 0 data 40404040", err, rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    test_reset();
    test_write_read();
    test_errors();
    test_conflict();
    test_back_to_back();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
